cond_unit_it: RTL and testbench

- Next-generation condition unit for the single-cycle/multicycle ARM-style core.
- Holds the architectural NZCV flag register and evaluates the 4-bit condition field against it.
- Gates the register-write, memory-write and PC-source controls for the current instruction.
- Adds IT-block predication: after an IT instruction, up to IT_MAX following instructions execute under a shared base condition or its inverse, selected per slot by a mask.

---
 rtl/cond_pkg.sv | 71 +++++++
 rtl/it_tracker.sv | 91 +++++++++
 rtl/cond_unit_it.sv | 97 +++++++++
 tb/tb_cond_unit_it.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared types and helpers for the condition unit: condition encodings,
// flag bit positions and the condition-evaluation function.
// Purely declarative; no latency, no flow control.
package cond_pkg;

    // 4-bit instruction condition field encodings.
    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    // Bit positions inside the {N,Z,C,V} flag vector.
    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    // Evaluate a condition against {N,Z,C,V}.
    // Returns {pass, undef}; NV never passes and flags the encoding as undefined.
    function automatic logic [1:0] cond_eval(input cond_e c, input logic [3:0] flags);
        logic n;
        logic z;
        logic cf;
        logic v;
        logic pass;
        logic undef;
        n     = flags[N_IDX];
        z     = flags[Z_IDX];
        cf    = flags[C_IDX];
        v     = flags[V_IDX];
        pass  = 1'b0;
        undef = 1'b0;
        case (c)
            EQ:      pass = z;
            NE:      pass = ~z;
            CS:      pass = cf;
            CC:      pass = ~cf;
            MI:      pass = n;
            PL:      pass = ~n;
            VS:      pass = v;
            VC:      pass = ~v;
            HI:      pass = ~z & cf;
            LS:      pass = z | ~cf;
            GE:      pass = (n == v);
            LT:      pass = (n != v);
            GT:      pass = ~z & (n == v);
            LE:      pass = z | (n != v);
            AL:      pass = 1'b1;
            default: begin
                pass  = 1'b0;
                undef = 1'b1;
            end
        endcase
        return {pass, undef};
    endfunction

endpackage

// File: rtl/it_tracker.sv
// IT-block tracker: holds slot counter, slot mask and base condition; yields the effective condition.
// Latency: effective condition / it_err combinational; IT state updates on the next clk edge.
// Backpressure: state frozen unless advance (InstrValid & ~Stall); flush clears even when stalled.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   advance                 current instruction is retiring this cycle
//   flush                   drop any in-flight IT block
//   it_start/it_cond/it_mask/it_len   IT instruction request
//   cond                    condition field of the current instruction
//   pc_src                  current instruction is a taken PC write
//   it_active, it_err       tracker status
//   eff_cond                condition to evaluate for the current instruction
module it_tracker
    import cond_pkg::*;
#(
    parameter int IT_MAX = 4,
    parameter int LEN_W  = $clog2(IT_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic              flush,
    input  logic              it_start,
    input  logic [3:0]        it_cond,
    input  logic [IT_MAX-1:0] it_mask,
    input  logic [LEN_W-1:0]  it_len,
    input  logic [3:0]        cond,
    input  logic              pc_src,
    output logic              it_active,
    output logic              it_err,
    output logic [3:0]        eff_cond
);

    logic [LEN_W-1:0]  cnt_q;
    logic [IT_MAX-1:0] mask_q;
    logic [3:0]        itcond_q;

    logic len_ok;
    logic load;

    assign it_active = (cnt_q != '0);

    // A usable IT length is 1..IT_MAX; anything else is rejected without loading.
    assign len_ok = (it_len != '0) && (it_len <= LEN_W'(IT_MAX));
    assign load   = advance & it_start & ~it_active & len_ok;
    assign it_err = advance & it_start & (it_active | ~len_ok);

    // Slot condition: base or its inverse (LSB flip) per mask bit. An AL base
    // must stay AL; flipping its LSB would otherwise produce the NV encoding.
    always_comb begin
        eff_cond = cond;
        if (it_active) begin
            if (cond_e'(itcond_q) == AL) begin
                eff_cond = AL;
            end else if (mask_q[0]) begin
                eff_cond = itcond_q;
            end else begin
                eff_cond = {itcond_q[3:1], ~itcond_q[0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            mask_q   <= '0;
            itcond_q <= '0;
        end else if (flush) begin
            // Base condition is left as-is; it is unused once the counter is zero.
            cnt_q  <= '0;
            mask_q <= '0;
        end else if (advance) begin
            if (it_active) begin
                // Every slot consumes one mask bit whether it passed or not.
                mask_q <= mask_q >> 1;
                // A taken branch leaves the block; remaining slots are abandoned.
                if (pc_src) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q - LEN_W'(1);
                end
            end else if (load) begin
                cnt_q    <= it_len;
                mask_q   <= it_mask;
                itcond_q <= it_cond;
            end
        end
    end

endmodule

// File: rtl/cond_unit_it.sv
// Condition unit with IT predication: NZCV register, condition check, write gating.
// Latency: CondEx and write enables combinational; Flags visible to the next instruction (1 cycle, no bypass).
// Backpressure: all state holds while Stall is high or InstrValid is low; Flush still clears IT state.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   InstrValid, Stall, Flush            pipeline control
//   Cond, ALUFlags, FlagW               condition field, ALU result flags, flag write mask
//   PCS, RegW, MemW, NoWrite            raw instruction write controls
//   ItStart, ItCond, ItMask, ItLen      IT instruction request
//   CondEx, PCSrc, RegWrite, MemWrite   gated results
//   Flags, ItActive, Undef, ItErr       status
module cond_unit_it
    import cond_pkg::*;
#(
    parameter int IT_MAX = 4,
    parameter int LEN_W  = $clog2(IT_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              InstrValid,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [3:0]        Cond,
    input  logic [3:0]        ALUFlags,
    input  logic [1:0]        FlagW,
    input  logic              PCS,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              NoWrite,
    input  logic              ItStart,
    input  logic [3:0]        ItCond,
    input  logic [IT_MAX-1:0] ItMask,
    input  logic [LEN_W-1:0]  ItLen,
    output logic              CondEx,
    output logic              PCSrc,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic [3:0]        Flags,
    output logic              ItActive,
    output logic              Undef,
    output logic              ItErr
);

    logic       advance;
    logic [3:0] eff_cond;
    logic [1:0] eval;
    logic [3:0] flags_q;

    assign advance = InstrValid & ~Stall;

    it_tracker #(
        .IT_MAX (IT_MAX),
        .LEN_W  (LEN_W)
    ) u_it_tracker (
        .clk       (clk),
        .reset     (reset),
        .advance   (advance),
        .flush     (Flush),
        .it_start  (ItStart),
        .it_cond   (ItCond),
        .it_mask   (ItMask),
        .it_len    (ItLen),
        .cond      (Cond),
        .pc_src    (PCSrc),
        .it_active (ItActive),
        .it_err    (ItErr),
        .eff_cond  (eff_cond)
    );

    // Evaluated against the registered flags only: an instruction never sees
    // flags produced by itself.
    assign eval   = cond_eval(cond_e'(eff_cond), flags_q);
    assign CondEx = eval[1];
    assign Undef  = eval[0];

    assign PCSrc    = PCS & CondEx;
    assign RegWrite = RegW & CondEx & ~NoWrite;
    assign MemWrite = MemW & CondEx;
    assign Flags    = flags_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else if (advance && CondEx) begin
            if (FlagW[1]) begin
                flags_q[N_IDX] <= ALUFlags[N_IDX];
                flags_q[Z_IDX] <= ALUFlags[Z_IDX];
            end
            if (FlagW[0]) begin
                flags_q[C_IDX] <= ALUFlags[C_IDX];
                flags_q[V_IDX] <= ALUFlags[V_IDX];
            end
        end
    end

endmodule

// File: tb/tb_cond_unit_it.sv
// Directed self-checking bench for cond_unit_it (IT_MAX = 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Every expected value below is hand-derived from the condition table and IT rules.
module tb_cond_unit_it;

    logic       clk;
    logic       reset;
    logic       InstrValid;
    logic       Stall;
    logic       Flush;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       ItStart;
    logic [3:0] ItCond;
    logic [3:0] ItMask;
    logic [2:0] ItLen;
    logic       CondEx;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;
    logic       ItActive;
    logic       Undef;
    logic       ItErr;

    int vec_cnt = 0;
    int err_cnt = 0;

    cond_unit_it #(.IT_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .InstrValid (InstrValid),
        .Stall      (Stall),
        .Flush      (Flush),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .NoWrite    (NoWrite),
        .ItStart    (ItStart),
        .ItCond     (ItCond),
        .ItMask     (ItMask),
        .ItLen      (ItLen),
        .CondEx     (CondEx),
        .PCSrc      (PCSrc),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .Flags      (Flags),
        .ItActive   (ItActive),
        .Undef      (Undef),
        .ItErr      (ItErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for combinational outputs to settle after an input change.
    task automatic settle();
        #1;
    endtask

    // Valid, non-writing AL instruction with no IT request.
    task automatic defaults();
        InstrValid = 1'b1;
        Stall      = 1'b0;
        Flush      = 1'b0;
        Cond       = 4'b1110;
        ALUFlags   = 4'b0000;
        FlagW      = 2'b00;
        PCS        = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        NoWrite    = 1'b0;
        ItStart    = 1'b0;
        ItCond     = 4'b0000;
        ItMask     = 4'b0000;
        ItLen      = 3'd0;
    endtask

    initial begin
        defaults();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state, EQ fails with Z=0
        Cond = 4'b0000; RegW = 1'b1;
        settle();
        check("rst_flags", Flags, 8'h0);
        check("rst_itactive", ItActive, 8'h0);
        check("eq_z0_condex", CondEx, 8'h0);
        check("eq_z0_regwrite", RegWrite, 8'h0);

        // SUBS-style compare: AL, NoWrite, writes NZCV = 0100
        tick();
        defaults();
        NoWrite = 1'b1; RegW = 1'b1; FlagW = 2'b11; ALUFlags = 4'b0100;
        settle();
        check("cmp_regwrite", RegWrite, 8'h0);
        check("cmp_flags_before", Flags, 8'h0);
        tick();
        check("cmp_flags_after", Flags, 8'h4);

        // EQ now passes, NE fails
        defaults();
        Cond = 4'b0000; RegW = 1'b1; MemW = 1'b1;
        settle();
        check("eq_z1_regwrite", RegWrite, 8'h1);
        check("eq_z1_memwrite", MemWrite, 8'h1);
        tick();
        Cond = 4'b0001;
        settle();
        check("ne_z1_regwrite", RegWrite, 8'h0);

        // Clear flags, then partial write of N,Z only
        tick();
        defaults();
        FlagW = 2'b11; ALUFlags = 4'b0000;
        tick();
        check("flags_cleared", Flags, 8'h0);
        FlagW = 2'b10; ALUFlags = 4'b1111;
        tick();
        check("flagw_nz_only", Flags, 8'hC);

        // Failing instruction (NE with Z=1) must not write flags
        Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b0000;
        settle();
        check("ne_fail_condex", CondEx, 8'h0);
        tick();
        check("fail_no_flagwrite", Flags, 8'hC);

        // Condition table spot checks on NZCV = 1100
        defaults();
        Cond = 4'b0100; settle(); check("mi_n1", CondEx, 8'h1);
        Cond = 4'b1010; settle(); check("ge_n1v0", CondEx, 8'h0);
        Cond = 4'b1011; settle(); check("lt_n1v0", CondEx, 8'h1);
        Cond = 4'b1000; settle(); check("hi_z1c0", CondEx, 8'h0);
        Cond = 4'b1001; settle(); check("ls_z1c0", CondEx, 8'h1);
        Cond = 4'b1101; settle(); check("le_z1", CondEx, 8'h1);

        // Stalled flag write is ignored
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0011; Stall = 1'b1;
        tick();
        check("stall_no_flagwrite", Flags, 8'hC);

        // NV: undefined, nothing written
        defaults();
        Cond = 4'b1111; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
        settle();
        check("nv_undef", Undef, 8'h1);
        check("nv_condex", CondEx, 8'h0);
        check("nv_writes", {5'b0, PCSrc, RegWrite, MemWrite}, 8'h0);

        // IT EQ, len 3, mask 101 with Z=1: slots pass, fail, pass
        defaults();
        ItStart = 1'b1; ItCond = 4'b0000; ItLen = 3'd3; ItMask = 4'b0101;
        settle();
        check("it_load_err", ItErr, 8'h0);
        check("it_instr_own_cond", CondEx, 8'h1);
        tick();
        check("it_active", ItActive, 8'h1);
        defaults();
        Cond = 4'b1111; RegW = 1'b1;   // ignored inside the block
        settle();
        check("slot1_condex", CondEx, 8'h1);
        check("slot1_undef", Undef, 8'h0);
        check("slot1_regwrite", RegWrite, 8'h1);
        tick();
        settle();
        check("slot2_condex", CondEx, 8'h0);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_slot2_condex", CondEx, 8'h0);
            check("stall_itactive", ItActive, 8'h1);
        end
        Stall = 1'b0;
        tick();
        settle();
        check("slot3_condex", CondEx, 8'h1);
        tick();
        check("it_done", ItActive, 8'h0);
        Cond = 4'b0001;
        settle();
        check("post_it_ne", CondEx, 8'h0);

        // Flush during stall mid-block; flags untouched
        defaults();
        ItStart = 1'b1; ItCond = 4'b0001; ItLen = 3'd4; ItMask = 4'b1111;
        tick();
        defaults();
        settle();
        check("flushblk_slot1_ne", CondEx, 8'h0);
        tick();
        Stall = 1'b1; Flush = 1'b1;
        tick();
        check("flush_itactive", ItActive, 8'h0);
        check("flush_flags", Flags, 8'hC);

        // Nested IT request is an error; block keeps running
        defaults();
        ItStart = 1'b1; ItCond = 4'b0000; ItLen = 3'd3; ItMask = 4'b0111;
        tick();
        defaults();
        ItStart = 1'b1; ItLen = 3'd2; ItMask = 4'b0000; ItCond = 4'b0001;
        settle();
        check("nested_iterr", ItErr, 8'h1);
        tick();
        ItStart = 1'b0;
        settle();
        check("nested_still_active", ItActive, 8'h1);
        check("nested_not_reloaded", CondEx, 8'h1);

        // Taken branch inside block ends it
        PCS = 1'b1;
        settle();
        check("it_branch_pcsrc", PCSrc, 8'h1);
        tick();
        check("branch_ends_it", ItActive, 8'h0);

        // Illegal lengths
        defaults();
        ItStart = 1'b1; ItCond = 4'b0000; ItLen = 3'd0;
        settle();
        check("len0_iterr", ItErr, 8'h1);
        tick();
        check("len0_no_load", ItActive, 8'h0);
        ItLen = 3'd5;
        settle();
        check("len5_iterr", ItErr, 8'h1);
        tick();
        check("len5_no_load", ItActive, 8'h0);
        Stall = 1'b1;
        settle();
        check("stall_no_iterr", ItErr, 8'h0);

        // Flush wins over an IT load in the same cycle
        defaults();
        ItStart = 1'b1; ItCond = 4'b0000; ItLen = 3'd2; ItMask = 4'b0011; Flush = 1'b1;
        tick();
        check("flush_beats_load", ItActive, 8'h0);

        // AL base with inverse mask still means AL
        defaults();
        ItStart = 1'b1; ItCond = 4'b1110; ItLen = 3'd2; ItMask = 4'b0000;
        tick();
        defaults();
        settle();
        check("al_base_condex", CondEx, 8'h1);
        check("al_base_undef", Undef, 8'h0);

        // Reset wins over Stall
        Stall = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_flags", Flags, 8'h0);
        check("reset_itactive", ItActive, 8'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
